rr_mux: RTL and testbench

Parametrised N-channel, W-bit arbitrating multiplexer with a registered output stage. It generalises the two-input combinational `mux2` to N producers, each with valid/ready handshakes. A selected word is held in a one-entry output register until the consumer accepts it. It sits between multiple datapath producers and a single shared consumer, for example a register-file write port or a bus.

---
 rtl/mux_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/rr_mux.sv | 57 +++++
 tb/tb_rr_mux.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and the rotating-priority pick used by the rr_mux arbiter.
package mux_pkg;

  typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_t;

  localparam int MAXN = 16;

  // One-hot grant: the first set bit of valid[n-1:0] scanning upward from ptr, wrapping at n.
  function automatic logic [MAXN-1:0] rr_pick(input logic [MAXN-1:0] valid,
                                               input logic [3:0]      ptr,
                                               input int              n);
    logic [MAXN-1:0] g;
    logic [4:0]      idx;
    g = '0;
    // Descending scan so the earliest position in rotation order overwrites later ones.
    for (int k = MAXN - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = {1'b0, ptr} + 5'(k);
        if (idx >= 5'(n)) idx = idx - 5'(n);
        if (valid[idx[3:0]]) g = MAXN'(1) << idx;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin / fixed-priority grant; owns the rotation pointer.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic [N-1:0]    in_valid,
  input  logic            fire,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] gidx,
  output logic            gvalid
);

  logic [SELW-1:0] ptr;
  logic [MAXN-1:0] pick;
  logic            fixed;

  assign fixed = (arb_mode_t'(mode) == ARB_FIXED);

  always_comb begin
    pick   = rr_pick(MAXN'(in_valid), fixed ? 4'd0 : 4'(ptr), N);
    grant  = pick[N-1:0];
    gvalid = |grant;
    gidx   = '0;
    for (int i = 0; i < N; i++)
      if (grant[i]) gidx = SELW'(i);
  end

  // Pointer moves just past the winner, and only for round-robin transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else if (fire && !fixed)
      ptr <= (gidx == SELW'(N - 1)) ? '0 : gidx + 1'b1;
  end

endmodule

// File: rtl/rr_mux.sv
// N-channel arbitrating mux with valid/ready handshakes and a one-entry output register.
module rr_mux
  import mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [N-1:0]      in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]      in_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [SELW-1:0]   out_sel,
  input  logic              out_ready
);

  logic [N-1:0]    grant;
  logic [SELW-1:0] gidx;
  logic            gvalid;
  logic            can_take;
  logic            fire;

  assign can_take = !out_valid || out_ready;
  // Reset gating keeps in_ready low while the register is being cleared.
  assign fire     = can_take && gvalid && !reset;
  assign in_ready = grant & {N{fire}};

  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .in_valid (in_valid),
    .fire     (fire),
    .grant    (grant),
    .gidx     (gidx),
    .gvalid   (gvalid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(gidx)*WIDTH +: WIDTH];
      out_sel   <= gidx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// Directed and random checks of rr_mux against a cycle-level reference model.
module tb_rr_mux;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           mode;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         mptr;
  bit         mv;
  logic [W-1:0] md;
  int         ms;

  rr_mux #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic int ref_grant();
    if (mode) begin
      for (int i = 0; i < N; i++) if (in_valid[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) if (in_valid[(mptr + k) % N]) return (mptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mptr = 0; mv = 0; md = '0; ms = 0;
  endtask

  // One clock: check in_ready before the edge, update model, check outputs after.
  task automatic cyc();
    int g;
    bit can;
    logic [N-1:0] er;
    #1;
    g   = ref_grant();
    can = !mv || out_ready;
    er  = (can && g >= 0) ? N'(1 << g) : '0;
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (can && g >= 0) begin
      mv = 1; md = in_data[g*W +: W]; ms = g;
      if (!mode) mptr = (g + 1) % N;
    end else if (mv && out_ready) begin
      mv = 0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(mv));
    chk("out_data",  32'(out_data),  32'(md));
    chk("out_sel",   32'(out_sel),   32'(ms));
  endtask

  initial begin
    logic [W-1:0] saved;
    bit seen3;
    model_reset();
    reset = 1; mode = 0; out_ready = 1;
    in_valid = 4'b1111;
    in_data = {16'h1234, 16'habcd, 16'hbeef, 16'hdead};
    #2;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_sel", 32'(out_sel), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 0;

    // rotation: sel 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_sel", 32'(out_sel), 32'(i % N));
    end
    chk("rr_data", 32'(out_data), 32'h dead);

    // single channel
    in_valid = 4'b0010; in_data[1*W +: W] = 16'hbeef;
    cyc();
    chk("single_sel", 32'(out_sel), 1);
    chk("single_data", 32'(out_data), 32'hbeef);

    // backpressure
    in_valid = 4'b1111;
    cyc();
    saved = out_data;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold", 32'(out_data), 32'(saved));
    end
    out_ready = 1;
    cyc();
    chk("bp_reload_valid", 32'(out_valid), 1);

    // fixed priority starves channel 3
    mode = 1; in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("fixed_sel", 32'(out_sel), 1);
    end
    mode = 0; seen3 = 0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      if (out_sel == 2'd3) seen3 = 1;
    end
    chk("rr_unstarve", 32'(seen3), 1);

    // idle drain
    saved = out_data;
    in_valid = 4'b0000;
    cyc();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_data", 32'(out_data), 32'(saved));

    // reset mid-stream with a word held
    in_valid = 4'b0100; in_data[2*W +: W] = 16'h5a5a; out_ready = 0;
    cyc();
    chk("mid_held", 32'(out_valid), 1);
    reset = 1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_sel", 32'(out_sel), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    model_reset();
    @(posedge clk); #1;
    reset = 0; out_ready = 1; in_valid = 4'b1010;
    cyc();
    chk("post_rst_sel", 32'(out_sel), 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      mode      = ($urandom_range(0, 3) == 0);
      in_valid  = N'($urandom);
      for (int c = 0; c < N; c++) in_data[c*W +: W] = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
